// File: rtl/row_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : row_clear_ctrl
//  Purpose  : Line-clear sequencer for the playfield row PIO bank. Keeps a
//             shadow copy of every row, removes full rows by collapsing the
//             stack downward, then writes each changed row to its PIO slave
//             over an Avalon-MM write master.
//  Options  : ROW_CLEAR_SCORE_EN adds a saturating 16-bit score output that
//             accumulates line-clear points at the end of each sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module row_clear_ctrl #(
  parameter int NUM_ROWS  = 20,
  parameter int COLS      = 10,
  parameter int CELL_W    = 3,
  parameter int ROW_W     = COLS * CELL_W,
  parameter int IDX_W     = 5,
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [IDX_W-1:0]  ld_row,
  input  logic [ROW_W-1:0]  ld_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  lines_cleared,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [31:0]       m_writedata,
  input  logic              m_waitrequest
`ifdef ROW_CLEAR_SCORE_EN
  ,
  output logic [15:0]       score
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_SHIFT = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [ROW_W-1:0]     rows_q [NUM_ROWS];
  logic [ROW_W-1:0]     rows_d [NUM_ROWS];
  logic [NUM_ROWS-1:0]  dirty_q, dirty_d;
  logic [IDX_W-1:0]     r_q, r_d;          // scan index
  logic [IDX_W-1:0]     s_q, s_d;          // shift pointer
  logic [IDX_W-1:0]     f_q, f_d;          // row currently on the master bus
  logic [IDX_W-1:0]     lines_q, lines_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 m_write_q, m_write_d;
  logic [ADDR_W-1:0]    m_address_q, m_address_d;
  logic [31:0]          m_writedata_q, m_writedata_d;

  logic [NUM_ROWS-1:0]  flush_pend;
  logic                 flush_any;
  logic [IDX_W-1:0]     flush_next;
  logic                 wr_done;

  // A row is full only when every cell carries a nonzero colour code.
  function automatic logic row_full(input logic [ROW_W-1:0] row);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (row[c*CELL_W +: CELL_W] == '0) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [ADDR_W-1:0] row_addr(input logic [IDX_W-1:0] idx);
    return ADDR_W'(BASE_ADDR) + (ADDR_W'(idx) << 4);
  endfunction

  assign wr_done = (state_q == S_FLUSH) && m_write_q && !m_waitrequest;

  // Highest pending dirty row, excluding the one whose write completes now.
  always_comb begin
    flush_pend = dirty_q;
    if (wr_done) flush_pend[f_q] = 1'b0;
    flush_any  = |flush_pend;
    flush_next = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (flush_pend[i]) flush_next = IDX_W'(i);
    end
  end

  // Sequencer next-state: scan, collapse, flush and completion handshake.
  always_comb begin
    state_d       = state_q;
    rows_d        = rows_q;
    dirty_d       = dirty_q;
    r_d           = r_q;
    s_d           = s_q;
    f_d           = f_q;
    lines_d       = lines_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    m_write_d     = m_write_q;
    m_address_d   = m_address_q;
    m_writedata_d = m_writedata_q;

    case (state_q)
      S_IDLE: begin
        if (ld_valid && (32'(ld_row) < NUM_ROWS)) rows_d[ld_row] = ld_data;
        if (start) begin
          state_d = S_SCAN;
          r_d     = IDX_W'(NUM_ROWS - 1);
          lines_d = '0;
          dirty_d = '0;
          busy_d  = 1'b1;
        end
      end

      S_SCAN: begin
        if (row_full(rows_q[r_q])) begin
          state_d = S_SHIFT;
          s_d     = r_q;
          if (lines_q < IDX_W'(NUM_ROWS)) lines_d = lines_q + 1'b1;
        end else if (r_q != '0) begin
          r_d = r_q - 1'b1;
        end else if (flush_any) begin
          // First write is presented on the bus as FLUSH is entered.
          state_d       = S_FLUSH;
          f_d           = flush_next;
          m_write_d     = 1'b1;
          m_address_d   = row_addr(flush_next);
          m_writedata_d = 32'(rows_q[flush_next]);
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end

      S_SHIFT: begin
        if (s_q != '0) begin
          rows_d[s_q]  = rows_q[s_q - 1'b1];
          dirty_d[s_q] = 1'b1;
          s_d          = s_q - 1'b1;
        end else begin
          // Top row refills empty; rescan the same index for a new full row.
          rows_d[0]  = '0;
          dirty_d[0] = 1'b1;
          state_d    = S_SCAN;
        end
      end

      S_FLUSH: begin
        if (wr_done) begin
          dirty_d = flush_pend;
          if (flush_any) begin
            f_d           = flush_next;
            m_address_d   = row_addr(flush_next);
            m_writedata_d = 32'(rows_q[flush_next]);
          end else begin
            m_write_d = 1'b0;
            state_d   = S_DONE;
            done_d    = 1'b1;
            busy_d    = 1'b0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and shadow registers; reset abandons any write in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < NUM_ROWS; i++) rows_q[i] <= '0;
      dirty_q       <= '0;
      r_q           <= '0;
      s_q           <= '0;
      f_q           <= '0;
      lines_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
    end else begin
      state_q       <= state_d;
      rows_q        <= rows_d;
      dirty_q       <= dirty_d;
      r_q           <= r_d;
      s_q           <= s_d;
      f_q           <= f_d;
      lines_q       <= lines_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      m_write_q     <= m_write_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_cleared = lines_q;
  assign m_write       = m_write_q;
  assign m_address     = m_address_q;
  assign m_writedata   = m_writedata_q;

`ifdef ROW_CLEAR_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [15:0] points;
  logic [16:0] score_sum;

  // Points for the finished sequence, added once in DONE with saturation.
  always_comb begin
    case (lines_q)
      IDX_W'(0): points = 16'd0;
      IDX_W'(1): points = 16'd40;
      IDX_W'(2): points = 16'd100;
      IDX_W'(3): points = 16'd300;
      default:   points = 16'd1200;
    endcase
    score_sum = {1'b0, score_q} + {1'b0, points};
    score_d   = score_q;
    if (state_q == S_DONE) score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  // Score accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score = score_q;
`endif

endmodule
`default_nettype wire
